// File: rtl/yuv_pkg.sv
// Shared constants for the YUV to RGB converter: the mode encoding, the
// Q12 coefficient table rescaled to any fractional width, and the offsets.
package yuv_pkg;

   typedef enum logic [1:0] {
      MODE_601_FULL = 2'd0,
      MODE_601_LIM  = 2'd1,
      MODE_709_LIM  = 2'd2,
      MODE_BYPASS   = 2'd3
   } yuv_mode_e;

   localparam int K_Y  = 0;
   localparam int K_RV = 1;
   localparam int K_GU = 2;
   localparam int K_GV = 3;
   localparam int K_BU = 4;

   // Rows by mode, columns kY, kRV, kGU, kGV, kBU in Q12. Bypass is an
   // identity on the Y term; the operand swap for G/B is done in the datapath.
   localparam int COEF_Q12 [4][5] = '{
      '{4096, 5743, 1410, 2925, 7258},
      '{4768, 6537, 1606, 3330, 8263},
      '{4768, 7344,  872, 2183, 8652},
      '{4096,    0,    0,    0,    0}
   };

   // Coefficient rescaled from Q12 to Q(frac), rounded to nearest.
   function automatic int coef(input logic [1:0] mode, input int idx, input int frac);
      int c;
      c = COEF_Q12[mode][idx];
      if (frac >= 12) coef = c <<< (frac - 12);
      else            coef = (c + (1 <<< (11 - frac))) >>> (12 - frac);
   endfunction

   // Luma offset: nonzero only for the limited-range modes.
   function automatic int y_off(input logic [1:0] mode, input int in_w);
      y_off = (mode == 2'd1 || mode == 2'd2) ? (16 <<< (in_w - 8)) : 0;
   endfunction

   // Chroma offset: bypass passes samples through untouched.
   function automatic int c_off(input logic [1:0] mode, input int in_w);
      c_off = (mode == 2'd3) ? 0 : (128 <<< (in_w - 8));
   endfunction

endpackage

// File: rtl/yuv_to_rgb_stream_if.sv
// Stream bundle for the converter. Handshake: a beat moves on a side
// whenever that side's valid and ready are both high at a rising clock edge;
// valid never waits for ready, ready may depend combinationally on valid.
interface yuv_to_rgb_stream_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  y;
   logic [IN_W-1:0]  u;
   logic [IN_W-1:0]  v;
   logic [1:0]       mode;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] r;
   logic [OUT_W-1:0] g;
   logic [OUT_W-1:0] b;
   logic             out_last;
   logic             out_sat;

   modport master (
      output in_valid, y, u, v, mode, in_last, out_ready,
      input  in_ready, out_valid, r, g, b, out_last, out_sat
   );

   modport slave (
      input  in_valid, y, u, v, mode, in_last, out_ready,
      output in_ready, out_valid, r, g, b, out_last, out_sat
   );
endinterface

// File: rtl/yuv_chan_mac.sv
// One output channel: sum of three signed product terms, round-half-up,
// arithmetic shift to the output width, clamp to 0..2^OUT_W-1.
module yuv_chan_mac #(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 8,
   parameter int COEF_FRAC = 12,
   parameter int PW        = 25
) (
   input  logic signed [PW-1:0] term_a,
   input  logic signed [PW-1:0] term_b,
   input  logic signed [PW-1:0] term_c,
   output logic [OUT_W-1:0]     res,
   output logic                 sat
);
   // Narrowing drops the extra input bits in the shift; widening keeps the
   // Q shift at COEF_FRAC and restores the scale with a left shift.
   localparam int SH = (IN_W >= OUT_W) ? (COEF_FRAC + IN_W - OUT_W) : COEF_FRAC;
   localparam int LS = (OUT_W > IN_W) ? (OUT_W - IN_W) : 0;
   localparam int SW = PW + 2 + LS;
   localparam logic signed [SW-1:0] HALF  = SW'(1) <<< (SH - 1);
   localparam logic signed [SW-1:0] MAX_V = (SW'(1) <<< OUT_W) - SW'(1);

   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] scaled;

   // A negative full-precision sum counts as clamped even if it would round to 0.
   always_comb begin
      sum    = {{(SW-PW){term_a[PW-1]}}, term_a}
             + {{(SW-PW){term_b[PW-1]}}, term_b}
             + {{(SW-PW){term_c[PW-1]}}, term_c};
      scaled = ((sum + HALF) >>> SH) <<< LS;
      res    = '0;
      sat    = 1'b0;
      if (sum[SW-1]) begin
         res = '0;
         sat = 1'b1;
      end else if (scaled > MAX_V) begin
         res = '1;
         sat = 1'b1;
      end else begin
         res = scaled[OUT_W-1:0];
      end
   end
endmodule

// File: rtl/yuv_to_rgb_stream.sv
// Three-stage YUV to RGB converter: S1 offset subtract, S2 multiply,
// S3 sum/round/clamp. All stages advance together; mode and last ride along.
module yuv_to_rgb_stream
   import yuv_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 8,
   parameter int COEF_FRAC = 12
) (
   input  logic             i_sysclk,
   input  logic             i_srst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [IN_W-1:0]  i_Y,
   input  logic [IN_W-1:0]  i_U,
   input  logic [IN_W-1:0]  i_V,
   input  logic [1:0]       i_mode,
   input  logic             i_last,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_R,
   output logic [OUT_W-1:0] o_G,
   output logic [OUT_W-1:0] o_B,
   output logic             o_last,
   output logic             o_sat
);
   localparam int DW = IN_W + 1;
   localparam int CW = COEF_FRAC + 4;
   localparam int PW = DW + CW;

   logic                 adv;
   logic                 v1, v2;
   logic signed [DW-1:0] d_y, d_u, d_v;
   logic signed [DW-1:0] yo_c, uo_c, vo_c;
   yuv_mode_e            m1, m2;
   logic                 l1, l2;
   logic signed [CW-1:0] k_y, k_rv, k_gu, k_gv, k_bu;
   logic signed [DW-1:0] ga_op, ba_op;
   logic signed [PW-1:0] n_r_a, n_r_b, n_g_a, n_g_b, n_g_c, n_b_a, n_b_b;
   logic signed [PW-1:0] t_r_a, t_r_b, t_g_a, t_g_b, t_g_c, t_b_a, t_b_b;
   logic [OUT_W-1:0]     r_n, g_n, b_n;
   logic                 sat_r, sat_g, sat_b;

   function automatic logic signed [PW-1:0] mul(input logic signed [CW-1:0] k,
                                                input logic signed [DW-1:0] d);
      mul = PW'(k) * PW'(d);
   endfunction

   assign adv     = i_ready | ~o_valid;
   assign o_ready = adv | ~i_srst_n;

   // Stage valids and output sideband; reset discards everything in flight.
   always_ff @(posedge i_sysclk) begin
      if (!i_srst_n) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         o_sat   <= 1'b0;
      end else if (adv) begin
         v1      <= i_valid;
         v2      <= v1;
         o_valid <= v2;
         o_last  <= v2 & l2;
         o_sat   <= v2 & (m2 != MODE_BYPASS) & (sat_r | sat_g | sat_b);
      end
   end

   // S1 offsets for the incoming beat's own mode.
   always_comb begin
      yo_c = DW'(y_off(i_mode, IN_W));
      uo_c = DW'(c_off(i_mode, IN_W));
      vo_c = DW'(c_off(i_mode, IN_W));
   end

   // S2 products; bypass routes U/V onto the G/B identity term.
   always_comb begin
      k_y   = CW'(coef(m1, K_Y,  COEF_FRAC));
      k_rv  = CW'(coef(m1, K_RV, COEF_FRAC));
      k_gu  = CW'(coef(m1, K_GU, COEF_FRAC));
      k_gv  = CW'(coef(m1, K_GV, COEF_FRAC));
      k_bu  = CW'(coef(m1, K_BU, COEF_FRAC));
      ga_op = (m1 == MODE_BYPASS) ? d_u : d_y;
      ba_op = (m1 == MODE_BYPASS) ? d_v : d_y;
      n_r_a = mul(k_y, d_y);
      n_r_b = mul(k_rv, d_v);
      n_g_a = mul(k_y, ga_op);
      n_g_b = -mul(k_gu, d_u);
      n_g_c = -mul(k_gv, d_v);
      n_b_a = mul(k_y, ba_op);
      n_b_b = mul(k_bu, d_u);
   end

   // Pipeline data registers; no reset, they only matter under a valid bit.
   always_ff @(posedge i_sysclk) begin
      if (adv) begin
         d_y   <= $signed({1'b0, i_Y}) - yo_c;
         d_u   <= $signed({1'b0, i_U}) - uo_c;
         d_v   <= $signed({1'b0, i_V}) - vo_c;
         m1    <= yuv_mode_e'(i_mode);
         l1    <= i_last;
         t_r_a <= n_r_a;
         t_r_b <= n_r_b;
         t_g_a <= n_g_a;
         t_g_b <= n_g_b;
         t_g_c <= n_g_c;
         t_b_a <= n_b_a;
         t_b_b <= n_b_b;
         m2    <= m1;
         l2    <= l1;
         o_R   <= r_n;
         o_G   <= g_n;
         o_B   <= b_n;
      end
   end

   yuv_chan_mac #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_FRAC(COEF_FRAC), .PW(PW)) u_mac_r (
      .term_a(t_r_a), .term_b(t_r_b), .term_c('0), .res(r_n), .sat(sat_r)
   );
   yuv_chan_mac #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_FRAC(COEF_FRAC), .PW(PW)) u_mac_g (
      .term_a(t_g_a), .term_b(t_g_b), .term_c(t_g_c), .res(g_n), .sat(sat_g)
   );
   yuv_chan_mac #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_FRAC(COEF_FRAC), .PW(PW)) u_mac_b (
      .term_a(t_b_a), .term_b(t_b_b), .term_c('0), .res(b_n), .sat(sat_b)
   );
endmodule

// File: tb/tb_yuv_to_rgb_stream.sv
// Bench for yuv_to_rgb_stream at default widths: directed spec vectors,
// streaming with stalls, mode alternation, random traffic, mid-stream reset.
module tb_yuv_to_rgb_stream;
   localparam int IN_W  = 8;
   localparam int OUT_W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   yuv_to_rgb_stream_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   yuv_to_rgb_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_FRAC(12)) dut (
      .i_sysclk(clk),          .i_srst_n(rst_n),
      .i_valid(bus.in_valid),  .o_ready(bus.in_ready),
      .i_Y(bus.y),             .i_U(bus.u),             .i_V(bus.v),
      .i_mode(bus.mode),       .i_last(bus.in_last),
      .o_valid(bus.out_valid), .i_ready(bus.out_ready),
      .o_R(bus.r),             .o_G(bus.g),             .o_B(bus.b),
      .o_last(bus.out_last),   .o_sat(bus.out_sat)
   );

   int          checks   = 0;
   int          failures = 0;
   int          n_out    = 0;
   logic [25:0] exp_q[$];
   logic [25:0] held;
   logic        held_v   = 1'b0;
   bit          rnd_bp   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Reference conversion from the published coefficients: {last,sat,r,g,b}.
   function automatic logic [25:0] model(input int mode, input int y, input int u,
                                         input int v, input bit last);
      int k[5];
      int s[3];
      int q[3];
      bit sat;
      int yo;
      if (mode == 3) return {last, 1'b0, 8'(y), 8'(u), 8'(v)};
      case (mode)
         0:       k = '{4096, 5743, 1410, 2925, 7258};
         1:       k = '{4768, 6537, 1606, 3330, 8263};
         default: k = '{4768, 7344,  872, 2183, 8652};
      endcase
      yo   = (mode == 0) ? 0 : 16;
      s[0] = k[0]*(y-yo) + k[1]*(v-128);
      s[1] = k[0]*(y-yo) - k[2]*(u-128) - k[3]*(v-128);
      s[2] = k[0]*(y-yo) + k[4]*(u-128);
      sat  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (s[c] < 0) begin
            q[c] = 0;
            sat  = 1'b1;
         end else begin
            q[c] = (s[c] + 2048) / 4096;
            if (q[c] > 255) begin
               q[c] = 255;
               sat  = 1'b1;
            end
         end
      end
      return {last, sat, 8'(q[0]), 8'(q[1]), 8'(q[2])};
   endfunction

   // Scoreboard: pop on output transfer, push on input transfer, hold check.
   always @(negedge clk) begin
      logic [25:0] cur;
      logic [25:0] e;
      cur = {bus.out_last, bus.out_sat, bus.r, bus.g, bus.b};
      if (!rst_n) begin
         exp_q.delete();
         held_v = 1'b0;
      end else begin
         if (held_v && bus.out_valid) chk("stall_hold", 32'(cur), 32'(held));
         held_v = bus.out_valid && !bus.out_ready;
         held   = cur;
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("beat_last_sat_rgb", 32'(cur), 32'(e));
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(int'(bus.mode), int'(bus.y), int'(bus.u), int'(bus.v), bus.in_last));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int mode, input int y, input int u, input int v, input bit last);
      bus.mode    = 2'(mode);
      bus.y       = 8'(y);
      bus.u       = 8'(u);
      bus.v       = 8'(v);
      bus.in_last = last;
   endtask

   task automatic send(input int mode, input int y, input int u, input int v, input bit last);
      set_beat(mode, y, u, v, last);
      bus.in_valid = 1'b1;
      for (int t = 0; t < 64; t++) begin
         if (rnd_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus.in_ready) begin
            step();
            bus.in_valid = 1'b0;
            return;
         end
         step();
      end
      chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 64; t++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      step();
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic wait_out();
      for (int t = 0; t < 16; t++) begin
         if (bus.out_valid) break;
         step();
      end
      chk("wait_out_valid", bus.out_valid, 1);
   endtask

   initial begin
      int by[16], bu[16], bv[16], bm[16];
      int n0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      set_beat(0, 0, 0, 0, 1'b0);
      step();
      step();
      // Reset state; a beat offered during reset must vanish.
      chk("rst_o_valid", bus.out_valid, 0);
      chk("rst_o_last", bus.out_last, 0);
      chk("rst_o_sat", bus.out_sat, 0);
      chk("rst_o_ready", bus.in_ready, 1);
      set_beat(0, 200, 10, 30, 1'b1);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      step();
      step();
      step();
      step();
      chk("rst_beat_dropped", n_out, 0);

      // Mid-grey in full range, exact 3-cycle latency.
      set_beat(0, 128, 128, 128, 1'b0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("lat_ready", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      chk("lat_c1", bus.out_valid, 0);
      step();
      chk("lat_c2", bus.out_valid, 0);
      step();
      chk("lat_c3", bus.out_valid, 1);
      chk("grey_rgb", {bus.r, bus.g, bus.b}, {8'd128, 8'd128, 8'd128});
      chk("grey_sat", bus.out_sat, 0);
      drain();

      // Negative blue clamps and raises sat.
      send(0, 76, 85, 255, 1'b0);
      wait_out();
      chk("clamp_rgb", {bus.r, bus.g, bus.b}, {8'd254, 8'd0, 8'd0});
      chk("clamp_sat", bus.out_sat, 1);
      drain();

      // Limited-range black and white.
      send(1, 16, 128, 128, 1'b0);
      wait_out();
      chk("lim_black", {bus.out_sat, bus.r, bus.g, bus.b}, {1'b0, 8'd0, 8'd0, 8'd0});
      drain();
      send(1, 235, 128, 128, 1'b0);
      wait_out();
      chk("lim_white", {bus.out_sat, bus.r, bus.g, bus.b}, {1'b0, 8'd255, 8'd255, 8'd255});
      drain();

      // 16-beat stream with a 5-cycle output stall in the middle.
      for (int i = 0; i < 16; i++) begin
         bm[i] = $urandom_range(0, 3);
         by[i] = $urandom_range(0, 255);
         bu[i] = $urandom_range(0, 255);
         bv[i] = $urandom_range(0, 255);
      end
      n0 = n_out;
      for (int i = 0; i < 8; i++) send(bm[i], by[i], bu[i], bv[i], (i == 7));
      bus.out_ready = 1'b0;
      set_beat(bm[8], by[8], bu[8], bv[8], 1'b0);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("stall_valid", bus.out_valid, 1);
         chk("stall_o_ready", bus.in_ready, 0);
         step();
      end
      bus.out_ready = 1'b1;
      for (int i = 8; i < 16; i++) send(bm[i], by[i], bu[i], bv[i], (i == 15));
      drain();
      chk("stream_count", n_out - n0, 16);

      // Alternate full-range and bypass every beat.
      for (int i = 0; i < 12; i++)
         send((i % 2 == 0) ? 0 : 3, $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), (i == 11));
      drain();

      // Random traffic with random backpressure.
      rnd_bp = 1'b1;
      for (int i = 0; i < 80; i++)
         send($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), ($urandom_range(0, 7) == 0));
      rnd_bp = 1'b0;
      drain();

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) send(0, 100 + i, 90, 160, 1'b1);
      chk("flight_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      step();
      chk("midrst_o_valid", bus.out_valid, 0);
      chk("midrst_o_last", bus.out_last, 0);
      rst_n = 1'b1;
      n0 = n_out;
      for (int c = 0; c < 8; c++) step();
      chk("midrst_no_stale", n_out - n0, 0);
      chk("midrst_queue", exp_q.size(), 0);

      // Pipeline still works after the mid-stream reset.
      send(2, 180, 60, 200, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
